spd_info_frame_receiver: RTL
============================

// Module: spd_info_frame_receiver
// PURPOSE
//  Receive-side parser for the HDMI Source Product Description (SPD) InfoFrame (CEA-861-D 6.5).
//  Sits after the data-island packet decoder. Takes the de-BCH'd packet as a byte stream:
//  HB0..HB2, then PB0..PB27. Validates header and checksum, then publishes the vendor name,
//  product description and source device info in the same packed form the SPD transmitter
//  takes as parameters.
// PARAMETERS
//  PB25_IN_CHECKSUM  1  1: checksum spans HB0-2 + PB0..PB25 (CEA-861-D compliant).
//                       0: checksum spans HB0-2 + PB0..PB24 only (for interop with senders that omit SDI).
// PORTS
//  clk_pixel                  in   1    pixel clock; everything is synchronous to its rising edge
//  reset                      in   1    synchronous, active-high reset
//  in_valid                   in   1    in_byte is valid this cycle
//  in_sop                     in   1    qualified by in_valid; marks in_byte as HB0 (start of packet)
//  in_byte                    in   8    packet byte, sent in HB0,HB1,HB2,PB0..PB27 order
//  vendor_name                out  64   PB1..PB8; PB1 sits in [63:56]
//  product_description        out  128  PB9..PB24; PB9 sits in [127:120]
//  source_device_information  out  8    PB25
//  info_valid                 out  1    sticky; set by the first good packet, cleared only by reset
//  update                     out  1    1-cycle pulse when the outputs take a new good packet
//  checksum_error             out  1    1-cycle pulse when a packet with a good header fails its checksum
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, shadow buffer and running sum cleared.
//  FSM: IDLE -> HEADER -> BODY -> IDLE, plus DISCARD. A 5-bit idx counts accepted bytes.
//   IDLE:    ignore bytes without in_sop. in_valid&in_sop -> HEADER, idx=1, sum=in_byte.
//   HEADER:  expect HB0=8'h83, HB1=8'h01, HB2=8'h19 (upper 3 bits 0, length 25).
//            Any mismatch -> DISCARD. HB0 is checked on the sop byte; the mismatch is acted on
//            when HB2 arrives. All three match -> BODY.
//   BODY:    PB0..PB27 go into the shadow buffer. Add PB0..PB24 to sum (8-bit, wraps mod 256).
//            Add PB25 only if PB25_IN_CHECKSUM=1. PB26/PB27 are accepted but ignored.
//   DISCARD: drop all bytes until the next in_valid&in_sop.
//  in_valid=0 stalls the parse; gaps of any length are allowed and nothing times out.
//  in_valid&in_sop in any state aborts the current packet: no pulse, restart at HB0 with this byte.
//  On PB27 accepted at cycle N: if sum==0, then at N+1 the three data outputs load from the
//   shadow buffer, update=1 and info_valid=1. Otherwise checksum_error=1 at N+1 and the outputs
//   hold. Either way the FSM is in IDLE at N+1.
//   A sop byte at N+1 is accepted normally (back-to-back packets).
//  The data outputs change only on update and always hold one whole, consistent packet.
//  A reset in mid-packet drops the partial packet and raises no pulse.
// CONFIGURATION
//  `SPD_NUL_TO_ASCII0_EN defined: each PB1..PB24 byte equal to 8'h00 is published as 8'h30 ('0').
//   This undoes the transmitter's '0'->NUL padding so outputs compare directly with its parameters.
//   The checksum always uses the raw bytes.
//  Not defined: bytes are published unchanged.
// TESTING
//  1. Good packet: vendor "FPGAhdmi", product "HDMI-core-demo01", SDI=8'h0A, correct PB0,
//     contiguous in_valid -> update pulses once, 1 cycle after PB27. Outputs match;
//     vendor_name[63:56]=8'h46; info_valid=1.
//  2. Same packet with PB0+1 -> checksum_error pulses once, no update, outputs and info_valid unchanged.
//  3. HB0=8'h82 (AVI) followed by 30 bytes -> no pulses; a good SPD packet sent straight after
//     is accepted.
//  4. sop re-asserted at PB10, then a full good packet -> exactly one update, carrying the second
//     packet's data.
//  5. Random in_valid gaps (0-7 cycles) in packet 1 -> same result as test 1. Reset asserted at PB15,
//     then released -> outputs 0, info_valid=0, no pulses.
//  6. Vendor "AB\0\0\0\0\0\0" -> vendor_name=64'h4142303030303030 with the macro defined,
//     64'h4142000000000000 without it.
//     PB25_IN_CHECKSUM=0 with a checksum that excludes SDI=8'h0A -> update.

Source files
------------

// File: rtl/spd_info_frame_receiver.sv
// SPD InfoFrame receive parser: validates header and checksum, then publishes vendor/product/SDI fields.
// Optional feature macro: SPD_NUL_TO_ASCII0_EN (publish NUL bytes of PB1..PB24 as ASCII '0').
module spd_info_frame_receiver #(
    parameter bit PB25_IN_CHECKSUM = 1'b1
) (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         in_sop,
    input  logic [7:0]   in_byte,
    output logic [63:0]  vendor_name,
    output logic [127:0] product_description,
    output logic [7:0]   source_device_information,
    output logic         info_valid,
    output logic         update,
    output logic         checksum_error
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_BODY    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam logic [7:0] HB0_SPD  = 8'h83;
    localparam logic [7:0] HB1_VER  = 8'h01;
    localparam logic [7:0] HB2_LEN  = 8'h19;
    localparam logic [4:0] IDX_LAST = 5'd30;

    function automatic logic [7:0] publish_byte(input logic [7:0] b);
`ifdef SPD_NUL_TO_ASCII0_EN
        publish_byte = (b == 8'h00) ? 8'h30 : b;
`else
        publish_byte = b;
`endif
    endfunction

    state_t     state_r, state_n_s;
    logic [4:0] idx_r, idx_n_s;
    logic [7:0] sum_r, sum_n_s;
    logic       hdr_bad_r, hdr_bad_n_s;
    logic       wr_en_s, good_s, bad_s;
    logic [4:0] pb_s;
    logic [7:0] shadow_r [25];

    // idx holds the stream position of the byte being accepted; PBn sits at position n+3
    assign pb_s = idx_r - 5'd3;

    // Next-state, running checksum and end-of-packet verdict
    always_comb begin
        state_n_s   = state_r;
        idx_n_s     = idx_r;
        sum_n_s     = sum_r;
        hdr_bad_n_s = hdr_bad_r;
        wr_en_s     = 1'b0;
        good_s      = 1'b0;
        bad_s       = 1'b0;
        if (in_valid && in_sop) begin
            state_n_s   = ST_HEADER;
            idx_n_s     = 5'd1;
            sum_n_s     = in_byte;
            hdr_bad_n_s = (in_byte != HB0_SPD);
        end else if (in_valid) begin
            case (state_r)
                ST_IDLE: begin
                    state_n_s = ST_IDLE;
                end
                ST_HEADER: begin
                    idx_n_s = idx_r + 5'd1;
                    sum_n_s = sum_r + in_byte;
                    if (idx_r == 5'd1) begin
                        hdr_bad_n_s = hdr_bad_r | (in_byte != HB1_VER);
                    end else if (hdr_bad_r || (in_byte != HB2_LEN)) begin
                        state_n_s = ST_DISCARD;
                    end else begin
                        state_n_s = ST_BODY;
                    end
                end
                ST_BODY: begin
                    idx_n_s = idx_r + 5'd1;
                    if (pb_s <= 5'd24) begin
                        sum_n_s = sum_r + in_byte;
                    end else if ((pb_s == 5'd25) && PB25_IN_CHECKSUM) begin
                        sum_n_s = sum_r + in_byte;
                    end else begin
                        sum_n_s = sum_r;
                    end
                    wr_en_s = (pb_s >= 5'd1) && (pb_s <= 5'd25);
                    if (idx_r == IDX_LAST) begin
                        state_n_s = ST_IDLE;
                        idx_n_s   = 5'd0;
                        if (sum_r == 8'h00) begin
                            good_s = 1'b1;
                        end else begin
                            bad_s = 1'b1;
                        end
                    end else begin
                        state_n_s = ST_BODY;
                    end
                end
                ST_DISCARD: begin
                    state_n_s = ST_DISCARD;
                end
                default: begin
                    state_n_s = ST_IDLE;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // Parser state registers
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            idx_r     <= 5'd0;
            sum_r     <= 8'h00;
            hdr_bad_r <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            idx_r     <= idx_n_s;
            sum_r     <= sum_n_s;
            hdr_bad_r <= hdr_bad_n_s;
        end
    end

    // Shadow buffer for PB1..PB25 of the packet in flight
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            for (int k = 0; k < 25; k++) begin
                shadow_r[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 25; k++) begin
                if (wr_en_s && (pb_s == 5'(k + 1))) begin
                    shadow_r[k] <= in_byte;
                end
            end
        end
    end

    // Published outputs: loaded as a whole only when a packet passes its checksum
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            vendor_name               <= 64'h0;
            product_description       <= 128'h0;
            source_device_information <= 8'h00;
            info_valid                <= 1'b0;
            update                    <= 1'b0;
            checksum_error            <= 1'b0;
        end else begin
            update         <= good_s;
            checksum_error <= bad_s;
            if (good_s) begin
                for (int k = 0; k < 8; k++) begin
                    vendor_name[63 - 8*k -: 8] <= publish_byte(shadow_r[k]);
                end
                for (int k = 0; k < 16; k++) begin
                    product_description[127 - 8*k -: 8] <= publish_byte(shadow_r[8 + k]);
                end
                source_device_information <= shadow_r[24];
                info_valid                <= 1'b1;
            end
        end
    end

endmodule
